// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared geometry, FSM state encodings and cell addressing for
// the Sudoku player-input path.
//   CELULA_W : bits per cell (4)
//   N        : board side (9)
//   TAB_W    : flattened board width (324)
//   NCEL     : number of cells (81)
//   idx(l,c) : bit offset of cell (l,c) inside a [0:TAB_W-1] board vector
package sudoku_pkg;

  localparam int CELULA_W = 4;
  localparam int N        = 9;
  localparam int TAB_W    = 324;
  localparam int NCEL     = N * N;

  localparam logic [2:0] ST_RECEBE_LINHA  = 3'b000;
  localparam logic [2:0] ST_RECEBE_COLUNA = 3'b001;
  localparam logic [2:0] ST_VALIDA_VALOR  = 3'b010;
  localparam logic [2:0] ST_RECEBE_VALOR  = 3'b011;
  localparam logic [2:0] ST_VERIFICA_FIM  = 3'b100;
  localparam logic [2:0] ST_FIM_JOGO      = 3'b101;

  typedef enum logic [2:0] {
    RECEBE_LINHA  = ST_RECEBE_LINHA,
    RECEBE_COLUNA = ST_RECEBE_COLUNA,
    VALIDA_VALOR  = ST_VALIDA_VALOR,
    RECEBE_VALOR  = ST_RECEBE_VALOR,
    VERIFICA_FIM  = ST_VERIFICA_FIM,
    FIM_JOGO      = ST_FIM_JOGO
  } estado_t;

  function automatic int idx(input int l, input int c);
    return l * N * CELULA_W + c * CELULA_W;
  endfunction

endpackage

// File: rtl/verifica_conflito.sv
// verifica_conflito: 9-cycle peer scan that decides whether a pending value
// repeats in the target's row, column or 3x3 block.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : scan advances only while high
//   start       : one-cycle pulse, begins a scan (index 0 on the next cycle)
//   aborta      : one-cycle pulse, drops any scan in progress
//   linha/coluna: 0-based target cell, held stable for the whole scan
//   valor       : pending value, held stable; 0 never conflicts
//   tabuleiro   : player board, held stable for the whole scan
//   done        : high during the 9th scan cycle (index 8)
//   conflito    : valid together with done; 1 = some peer holds valor
// Handshake: start is accepted while idle; the scan occupies the 9 cycles
// after start; done/conflito are combinational in the last one so the
// caller can act on the same edge that closes the scan.
module verifica_conflito
  import sudoku_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             aborta,
  input  logic [3:0]       linha,
  input  logic [3:0]       coluna,
  input  logic [3:0]       valor,
  input  logic [0:TAB_W-1] tabuleiro,
  output logic             done,
  output logic             conflito
);

  logic       busy_q;
  logic       acc_q;
  logic [3:0] i_q;

  logic [6:0] r7, c7, i7, bl_r, bl_c;
  logic [6:0] cel_l, cel_c, cel_b;
  logic       hit;

  // Peer i: row cell (r,i), column cell (i,c) and the i-th cell of the block.
  always_comb begin
    r7    = {3'b000, linha};
    c7    = {3'b000, coluna};
    i7    = {3'b000, i_q};
    bl_r  = (r7 / 7'd3) * 7'd3 + i7 / 7'd3;
    bl_c  = (c7 / 7'd3) * 7'd3 + i7 % 7'd3;
    cel_l = r7 * 7'd9 + i7;
    cel_c = i7 * 7'd9 + c7;
    cel_b = bl_r * 7'd9 + bl_c;
    hit   = 1'b0;
    if (busy_q && valor != 4'd0) begin
      if (i7 != c7 && tabuleiro[{cel_l, 2'b00} +: CELULA_W] == valor)
        hit = 1'b1;
      if (i7 != r7 && tabuleiro[{cel_c, 2'b00} +: CELULA_W] == valor)
        hit = 1'b1;
      if (!(bl_r == r7 && bl_c == c7) &&
          tabuleiro[{cel_b, 2'b00} +: CELULA_W] == valor)
        hit = 1'b1;
    end
  end

  assign done     = busy_q && (i_q == 4'd8);
  assign conflito = acc_q | hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      acc_q  <= 1'b0;
      i_q    <= 4'd0;
    end else if (aborta) begin
      busy_q <= 1'b0;
      acc_q  <= 1'b0;
      i_q    <= 4'd0;
    end else if (start) begin
      busy_q <= 1'b1;
      acc_q  <= 1'b0;
      i_q    <= 4'd0;
    end else if (busy_q && enable) begin
      acc_q <= acc_q | hit;
      if (i_q == 4'd8) begin
        busy_q <= 1'b0;
        i_q    <= 4'd0;
      end else begin
        i_q <= i_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/entrada_jogada.sv
// entrada_jogada: player-move sequencer for the Sudoku game. Collects row,
// column and value from the switches (one confirma per step), refuses writes
// to given cells, owns the player board and detects a completed board.
// Optional feature macro: VALIDA_JOGADA_EN -- when defined, every move is
// checked against its row/column/block peers by verifica_conflito (9 cycles)
// and conflicting values are rejected; otherwise validaValor is 1 cycle and
// always accepts.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : low freezes all state and ignores every pulse
//   confirma          : one-cycle confirm pulse
//   cancela           : one-cycle abort pulse (recebeColuna / recebeValor)
//   entrada[3:0]      : switch value
//   carrega           : one-cycle pulse, loads tabuleiroInicial
//   tabuleiroInicial  : puzzle, cell (l,c) at bits idx(l,c) +: 4, 0 = empty
//   estadoJogo[2:0]   : FSM state (also the debug view of the FSM)
//   regLinha/regColuna: selected row/column 1..9, 0 = none
//   sudokuJogador     : player board, same layout as tabuleiroInicial
//   erroJogada        : one-cycle pulse after a rejected input
//   jogadas[7:0]      : accepted writes, saturating at 255
module entrada_jogada
  import sudoku_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             confirma,
  input  logic             cancela,
  input  logic [3:0]       entrada,
  input  logic             carrega,
  input  logic [0:TAB_W-1] tabuleiroInicial,
  output logic [2:0]       estadoJogo,
  output logic [3:0]       regLinha,
  output logic [3:0]       regColuna,
  output logic [0:TAB_W-1] sudokuJogador,
  output logic             erroJogada,
  output logic [7:0]       jogadas
);

  estado_t         estado_q, estado_n;
  logic [NCEL-1:0] fixas_q;
  logic [NCEL-1:0] nao_vazia;
  logic [3:0]      valor_q;
  logic [6:0]      varre_q;

  logic do_carrega, do_linha, do_coluna, do_limpa, do_valor;
  logic do_escreve, do_erro, varre_inc, varre_clr;

  logic [6:0] alvo_cel;
  logic [8:0] alvo_off;
  logic [3:0] cel_varre;
  logic       entrada_1a9;

  for (genvar k = 0; k < NCEL; k++) begin : g_nao_vazia
    assign nao_vazia[k] = |tabuleiroInicial[k*CELULA_W +: CELULA_W];
  end

  // Linear cell index k = l*9 + c, bit offset k*4; only meaningful once both
  // registers hold 1..9 (recebeValor onwards).
  assign alvo_cel    = ({3'b000, regLinha} - 7'd1) * 7'd9 + ({3'b000, regColuna} - 7'd1);
  assign alvo_off    = {alvo_cel, 2'b00};
  assign cel_varre   = sudokuJogador[{varre_q, 2'b00} +: CELULA_W];
  assign entrada_1a9 = (entrada != 4'd0) && (entrada <= 4'd9);
  assign estadoJogo  = estado_q;

`ifdef VALIDA_JOGADA_EN
  logic chk_start, chk_done, chk_conf;

  verifica_conflito u_verifica_conflito (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .start     (chk_start),
    .aborta    (enable && carrega),
    .linha     (regLinha - 4'd1),
    .coluna    (regColuna - 4'd1),
    .valor     (valor_q),
    .tabuleiro (sudokuJogador),
    .done      (chk_done),
    .conflito  (chk_conf)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= RECEBE_LINHA;
    else        estado_q <= estado_n;
  end

  // Next state and datapath strobes. Nothing fires while enable is low.
  always_comb begin
    estado_n   = estado_q;
    do_carrega = 1'b0;
    do_linha   = 1'b0;
    do_coluna  = 1'b0;
    do_limpa   = 1'b0;
    do_valor   = 1'b0;
    do_escreve = 1'b0;
    do_erro    = 1'b0;
    varre_inc  = 1'b0;
    varre_clr  = 1'b0;
`ifdef VALIDA_JOGADA_EN
    chk_start  = 1'b0;
`endif
    if (enable) begin
      if (carrega) begin
        do_carrega = 1'b1;
        estado_n   = RECEBE_LINHA;
      end else begin
        case (estado_q)
          RECEBE_LINHA: begin
            // cancela outranks confirma even though it has no effect here
            if (!cancela && confirma) begin
              if (entrada_1a9) begin
                do_linha = 1'b1;
                estado_n = RECEBE_COLUNA;
              end else begin
                do_erro = 1'b1;
              end
            end
          end
          RECEBE_COLUNA: begin
            if (cancela) begin
              do_limpa = 1'b1;
              estado_n = RECEBE_LINHA;
            end else if (confirma) begin
              if (entrada_1a9) begin
                do_coluna = 1'b1;
                estado_n  = RECEBE_VALOR;
              end else begin
                do_erro = 1'b1;
              end
            end
          end
          RECEBE_VALOR: begin
            if (cancela) begin
              do_limpa = 1'b1;
              estado_n = RECEBE_LINHA;
            end else if (confirma) begin
              if (entrada > 4'd9 || fixas_q[alvo_cel]) begin
                do_erro  = 1'b1;
                estado_n = RECEBE_LINHA;
              end else begin
                do_valor = 1'b1;
                estado_n = VALIDA_VALOR;
`ifdef VALIDA_JOGADA_EN
                chk_start = 1'b1;
`endif
              end
            end
          end
          VALIDA_VALOR: begin
`ifdef VALIDA_JOGADA_EN
            if (chk_done) begin
              if (chk_conf) begin
                do_erro  = 1'b1;
                estado_n = RECEBE_LINHA;
              end else begin
                do_escreve = 1'b1;
                estado_n   = VERIFICA_FIM;
              end
            end
`else
            do_escreve = 1'b1;
            estado_n   = VERIFICA_FIM;
`endif
          end
          VERIFICA_FIM: begin
            // One cell per cycle; the first empty cell ends the scan early.
            if (cel_varre == 4'd0) begin
              varre_clr = 1'b1;
              estado_n  = RECEBE_LINHA;
            end else if (varre_q == 7'd80) begin
              varre_clr = 1'b1;
              estado_n  = FIM_JOGO;
            end else begin
              varre_inc = 1'b1;
            end
          end
          FIM_JOGO: ;
          default: estado_n = RECEBE_LINHA;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regLinha      <= 4'd0;
      regColuna     <= 4'd0;
      sudokuJogador <= '0;
      fixas_q       <= '0;
      jogadas       <= 8'd0;
      erroJogada    <= 1'b0;
      valor_q       <= 4'd0;
      varre_q       <= 7'd0;
    end else begin
      erroJogada <= do_erro;
      if (do_carrega) begin
        sudokuJogador <= tabuleiroInicial;
        fixas_q       <= nao_vazia;
        regLinha      <= 4'd0;
        regColuna     <= 4'd0;
        jogadas       <= 8'd0;
        varre_q       <= 7'd0;
      end else begin
        if (do_linha)  regLinha  <= entrada;
        if (do_coluna) regColuna <= entrada;
        if (do_limpa) begin
          regLinha  <= 4'd0;
          regColuna <= 4'd0;
        end
        if (do_valor) valor_q <= entrada;
        if (do_escreve) begin
          sudokuJogador[alvo_off +: CELULA_W] <= valor_q;
          if (jogadas != 8'hFF) jogadas <= jogadas + 8'd1;
        end
        if (varre_clr)      varre_q <= 7'd0;
        else if (varre_inc) varre_q <= varre_q + 7'd1;
      end
    end
  end

endmodule

// File: doc/entrada_jogada.md
# entrada_jogada

Player-move input sequencer for the Sudoku game. Walks the player through row, column and value entry using switch input plus a confirm pulse. Rejects writes to puzzle-given cells and, optionally, values that conflict with the row, column or block. Owns and writes the player board `sudokuJogador`. Detects board completion. Drives `estadoJogo`, `regLinha`, `regColuna` and `sudokuJogador` to the hint-mode LED block and the display.

## Interface
- No parameters. Geometry is fixed: 9x9 cells, 4 bits per cell, 324-bit board.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high lets the block advance. Low freezes all state; `carrega` and `confirma` are ignored while low.
- `confirma`  in  1  one-cycle confirm pulse, already debounced.
- `cancela`  in  1  one-cycle abort pulse.
- `entrada`  in  4  switch value.
- `carrega`  in  1  one-cycle pulse that loads a new puzzle.
- `tabuleiroInicial`  in  [0:323]  puzzle. Cell (l,c) is at bits `l*36+c*4 +: 4`, with 0-based l and c. 0 means empty.
- `estadoJogo`  out  3  current FSM state encoding.
- `regLinha`  out  4  selected row, 1..9 (0 = none).
- `regColuna`  out  4  selected column, 1..9 (0 = none).
- `sudokuJogador`  out  [0:323]  player board, same layout as `tabuleiroInicial`.
- `erroJogada`  out  1  one-cycle pulse when an input is rejected.
- `jogadas`  out  8  count of accepted writes, saturates at 255.

## Operation
- Internal 81-bit `fixas` mask: bit set means the cell is a given and cannot be written.
- States and encodings:
  - `recebeLinha` = 000
  - `recebeColuna` = 001
  - `validaValor` = 010
  - `recebeValor` = 011
  - `verificaFim` = 100
  - `fimJogo` = 101
- Priority when `enable` = 1: `carrega`, then `cancela`, then `confirma`.
- `carrega`, from any state:
  - copy `tabuleiroInicial` into `sudokuJogador`;
  - set `fixas` bit for every nonzero cell;
  - clear `regLinha`, `regColuna` and `jogadas`;
  - go to `recebeLinha`.
- `recebeLinha` + `confirma`:
  - `entrada` in 1..9: latch it into `regLinha`, go to `recebeColuna`.
  - otherwise: pulse `erroJogada`, stay.
- `recebeColuna` + `confirma`:
  - `entrada` in 1..9: latch it into `regColuna`, go to `recebeValor`.
  - otherwise: pulse `erroJogada`, stay.
- `recebeValor` + `confirma`:
  - `entrada` > 9 or target cell fixed: pulse `erroJogada`, go to `recebeLinha`.
  - otherwise: latch `entrada` as the pending value, go to `validaValor`. Value 0 means erase.
- `cancela` in `recebeColuna` or `recebeValor`: clear `regLinha` and `regColuna`, go to `recebeLinha`.
- `cancela` and `confirma` are ignored in `validaValor`, `verificaFim` and `fimJogo`.
- `validaValor` accepts the move:
  - write the pending value into cell (`regLinha-1`, `regColuna-1`);
  - increment `jogadas`, saturating;
  - go to `verificaFim`.
  - Conflict checking is described under Configuration.
- `verificaFim`:
  - scan cells 0..80, one per cycle;
  - on the first zero cell, go to `recebeLinha` (early exit);
  - if all 81 cells are nonzero, go to `fimJogo`.
- `fimJogo`: hold until `carrega` or reset.
- Reset values:
  - state `recebeLinha`;
  - `regLinha`, `regColuna`, `sudokuJogador`, `fixas`, `jogadas` all 0;
  - `erroJogada` 0;
  - scan counters 0.
- Reset asserted mid-scan aborts the scan; no partial write survives.

## Timing
- All outputs are registered.
- `estadoJogo` changes on the edge after the confirm is sampled.
- `erroJogada` is high exactly the cycle after the rejecting `confirma`.
- The write happens on the last `validaValor` cycle and is visible the following cycle.
  - Without the feature: `validaValor` lasts 1 cycle; `confirma` at cycle t puts the write visible at t+2.
  - With the feature: `validaValor` lasts 9 cycles; the write is visible at t+10.
  - With the feature and a conflict: state returns to `recebeLinha` at t+10, `erroJogada` is high at t+10, no write.
- `verificaFim` lasts k+1 cycles when the first empty cell has index k; it lasts 81 cycles when the board is full.
- `enable` low mid-scan pauses the counter; the scan resumes unchanged when `enable` returns high.

## Configuration
- Macro: `VALIDA_JOGADA_EN`.
- Defined:
  - `validaValor` runs 9 cycles, index i = 0..8.
  - Each cycle compares the pending value against three peers: row cell (r,i), column cell (i,c), and block cell i.
  - The target cell itself is skipped.
  - A pending value of 0 never conflicts, but still takes the 9 cycles.
  - Any match: reject with `erroJogada`, go to `recebeLinha`, no write.
- Undefined: `validaValor` is one cycle and always accepts.

## Structure
- Package `sudoku_pkg` holds:
  - state localparams;
  - `CELULA_W` = 4, `N` = 9, `TAB_W` = 324;
  - cell-index function `idx(l,c) = l*36 + c*4`.
- Sub-module `verifica_conflito` holds the 9-cycle peer-scan counter and compare, with start/done/conflito handshake. It is instantiated only under `VALIDA_JOGADA_EN`.

## Test plan
- Reset, then load a puzzle with row 1 = 5,3,0,… → `estadoJogo` = 000, `jogadas` = 0. Entering row 1 → col 2 → value 7 pulses `erroJogada` (cell is fixed) and returns state to 000.
- Row 1 → col 3 → value 4, feature off → cell (0,2) = 4 two cycles after the last confirm; `jogadas` = 1.
- Feature on, row 1 already holds 5: row 1 → col 3 → value 5 → `erroJogada` 10 cycles later, board unchanged. Value 1 (no conflict) → written at t+10.
- Load a board with one empty cell (index 80), fill it → `verificaFim` takes 81 cycles, then `estadoJogo` = 101. A subsequent `confirma` is ignored.
- Row entry 0 and 10 → `erroJogada` each time, state stays 000. `cancela` in `recebeValor` → state 000, `regLinha` = `regColuna` = 0.
- `rst_n` low during `validaValor` → all outputs at reset values immediately; no write.
